// File: rtl/sequential_fp_divider.sv
// Multi-cycle IEEE-754-style divider: restoring radix-2 quotient,
// round-to-nearest-even, flush-to-zero on underflow, valid/ready on both sides.
module sequential_fp_divider #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] input_a,
    input  logic [W-1:0] input_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] output_z,
    output logic [3:0]   flags
);
    localparam int SW = MAN_W + 1;
    localparam int RW = SW + 1;
    localparam int QW = MAN_W + 3;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(QW + 1);
    localparam logic signed [EW-1:0] BIAS = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXP_W - 1);
    localparam logic [W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE
    } state_t;

    state_t                 state;
    logic [W-1:0]           a_r, b_r;
    logic                   sign_z;
    logic signed [EW-1:0]   exp_z;
    logic [RW-1:0]          rem;
    logic [SW-1:0]          div_r;
    logic [QW-1:0]          quo;
    logic                   sticky;
    logic [CW-1:0]          cnt;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sa, sb;

    always_comb begin
        sa = a_r[W-1];
        sb = b_r[W-1];
        ea = a_r[W-2 -: EXP_W];
        eb = b_r[W-2 -: EXP_W];
        fa = a_r[MAN_W-1:0];
        fb = b_r[MAN_W-1:0];
        a_nan = (&ea) && (|fa);
        b_nan = (&eb) && (|fb);
        a_inf = (&ea) && !(|fa);
        b_inf = (&eb) && !(|fb);
        // exp==0 covers true zero and denormals, which are flushed
        a_zero = (ea == '0);
        b_zero = (eb == '0);
    end

    logic          rem_ge;
    logic [RW-1:0] rem_sub;

    always_comb begin
        rem_ge = (rem >= {1'b0, div_r});
        rem_sub = rem_ge ? rem - {1'b0, div_r} : rem;
    end

    // quo[1] is guard, quo[0] round; the hidden bit sits at quo[QW-1]
    logic                 rnd_up;
    logic [MAN_W:0]       frac_sum;
    logic signed [EW-1:0] exp_r;

    always_comb begin
        rnd_up = quo[1] & (quo[0] | sticky | quo[2]);
        frac_sum = {1'b0, quo[QW-2:2]} + {{MAN_W{1'b0}}, rnd_up};
        exp_r = exp_z + {{(EW-1){1'b0}}, frac_sum[MAN_W]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            output_z  <= '0;
            flags     <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sign_z    <= 1'b0;
            exp_z     <= '0;
            rem       <= '0;
            div_r     <= '0;
            quo       <= '0;
            sticky    <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= input_a;
                        b_r      <= input_b;
                        in_ready <= 1'b0;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_z <= sa ^ sb;
                    exp_z  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
                    rem    <= {2'b01, fa};
                    div_r  <= {1'b1, fb};
                    quo    <= '0;
                    cnt    <= '0;
                    state  <= DONE;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        output_z  <= QNAN;
                        flags     <= 4'b1000;
                        out_valid <= 1'b1;
                    end else if (b_zero && !a_inf) begin
                        output_z  <= {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags     <= 4'b0100;
                        out_valid <= 1'b1;
                    end else if (a_inf) begin
                        output_z  <= {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        out_valid <= 1'b1;
                    end else if (a_zero || b_inf) begin
                        output_z  <= {sa ^ sb, {(W-1){1'b0}}};
                        out_valid <= 1'b1;
                    end else begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    quo <= {quo[QW-2:0], rem_ge};
                    rem <= rem_sub << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(QW - 1))
                        state <= NORM;
                end
                NORM: begin
                    sticky <= |rem;
                    if (!quo[QW-1]) begin
                        quo   <= quo << 1;
                        exp_z <= exp_z - 1'b1;
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    if (exp_r >= EMAX) begin
                        output_z <= {sign_z, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags    <= 4'b0010;
                    end else if (exp_r <= 0) begin
                        output_z <= {sign_z, {(W-1){1'b0}}};
                        flags    <= 4'b0001;
                    end else begin
                        output_z <= {sign_z, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                        flags    <= 4'b0000;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        flags     <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sequential_fp_divider.sv
// Scoreboard bench for sequential_fp_divider at default parameters:
// expectations queued at issue time, popped when out_valid appears.
module tb_sequential_fp_divider;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] input_a = '0;
    logic [31:0] input_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] output_z;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    sequential_fp_divider dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .input_a(input_a), .input_b(input_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .output_z(output_z), .flags(flags)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [3:0]  f;
        int          lat;
    } op_t;

    op_t exp_q[$];
    int  passed = 0;
    int  total = 0;

    task automatic send(input op_t o);
        exp_q.push_back(o);
        @(negedge clk);
        input_a  = o.a;
        input_b  = o.b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Edges counted from the acceptance edge; out_valid seen after edge n
    // is first sampled by the consumer at edge n+1.
    task automatic wait_valid(output int lat);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        lat = n + 1;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        op_t e;
        int  lat;
        #12;
        total++;
        if (out_valid !== 1'b0 || output_z !== 32'h0 || flags !== 4'h0) begin
            $display("FAIL reset_state: v=%b z=%h f=%b want 0/0/0",
                     out_valid, output_z, flags);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{"first_accept", 32'h40C00000, 32'h40000000,
                          32'h40400000, 4'h0, 30});
        input_a  = 32'h40C00000;
        input_b  = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            $display("FAIL first_accept: in_ready=%b want 0", in_ready);
        end else passed++;
        wait_valid(lat);
        e = exp_q.pop_front();
        total++;
        if (output_z !== e.z || flags !== e.f || lat != e.lat) begin
            $display("FAIL %s: z=%h f=%b lat=%0d want z=%h f=%b lat=%0d",
                     e.name, output_z, flags, lat, e.z, e.f, e.lat);
        end else passed++;
        take();
    endtask

    task automatic test_normal();
        op_t tbl[5] = '{
            '{"div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 30},
            '{"div1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, 30},
            '{"neg6_2",   32'hC0C00000, 32'h40000000, 32'hC0400000, 4'h0, 30},
            '{"div1_1",   32'h3F800000, 32'h3F800000, 32'h3F800000, 4'h0, 30},
            '{"div2_nh",  32'h40000000, 32'hBF000000, 32'hC0800000, 4'h0, 30}
        };
        op_t e;
        int  lat;
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_valid(lat);
            e = exp_q.pop_front();
            total++;
            if (output_z !== e.z || flags !== e.f || lat != e.lat) begin
                $display("FAIL %s: z=%h f=%b lat=%0d want z=%h f=%b lat=%0d",
                         e.name, output_z, flags, lat, e.z, e.f, e.lat);
            end else passed++;
            take();
        end
    endtask

    task automatic test_special();
        op_t tbl[8] = '{
            '{"neg1_0",   32'hBF800000, 32'h00000000, 32'hFF800000, 4'h4, 2},
            '{"zero_0",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'h8, 2},
            '{"nan_a",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h8, 2},
            '{"inf_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'h8, 2},
            '{"inf_2",    32'h7F800000, 32'h40000000, 32'h7F800000, 4'h0, 2},
            '{"two_inf",  32'h40000000, 32'hFF800000, 32'h80000000, 4'h0, 2},
            '{"denorm_a", 32'h00000001, 32'h3F800000, 32'h00000000, 4'h0, 2},
            '{"denorm_b", 32'h3F800000, 32'h80000001, 32'hFF800000, 4'h4, 2}
        };
        op_t e;
        int  lat;
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_valid(lat);
            e = exp_q.pop_front();
            total++;
            if (output_z !== e.z || flags !== e.f || lat != e.lat) begin
                $display("FAIL %s: z=%h f=%b lat=%0d want z=%h f=%b lat=%0d",
                         e.name, output_z, flags, lat, e.z, e.f, e.lat);
            end else passed++;
            take();
            total++;
            if (flags !== 4'h0) begin
                $display("FAIL %s_flags_clear: f=%b want 0000", e.name, flags);
            end else passed++;
        end
    endtask

    task automatic test_range();
        op_t tbl[2] = '{
            '{"overflow",  32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'h2, 30},
            '{"underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'h1, 30}
        };
        op_t e;
        int  lat;
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_valid(lat);
            e = exp_q.pop_front();
            total++;
            if (output_z !== e.z || flags !== e.f || lat != e.lat) begin
                $display("FAIL %s: z=%h f=%b lat=%0d want z=%h f=%b lat=%0d",
                         e.name, output_z, flags, lat, e.z, e.f, e.lat);
            end else passed++;
            take();
        end
    endtask

    task automatic test_backpressure();
        op_t e;
        int  lat;
        send('{"bp_ovf", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'h2, 30});
        wait_valid(lat);
        e = exp_q.pop_front();
        input_a  = 32'h40C00000;
        input_b  = 32'h40000000;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 total++;
            if (out_valid !== 1'b1 || output_z !== e.z || flags !== e.f
                || in_ready !== 1'b0) begin
                $display("FAIL bp_hold%0d: v=%b z=%h f=%b rdy=%b want 1/%h/%b/0",
                         k, out_valid, output_z, flags, in_ready, e.z, e.f);
            end else passed++;
        end
        take();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags !== 4'h0) begin
            $display("FAIL bp_release: v=%b rdy=%b f=%b want 0/1/0000",
                     out_valid, in_ready, flags);
        end else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        op_t e;
        int  lat;
        for (int k = 0; k < 2; k++) begin
            if (k == 0)
                send('{"b2b_0", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, 30});
            else
                send('{"b2b_1", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'h4, 2});
            wait_valid(lat);
            e = exp_q.pop_front();
            total++;
            if (output_z !== e.z || flags !== e.f || lat != e.lat) begin
                $display("FAIL %s: z=%h f=%b lat=%0d want z=%h f=%b lat=%0d",
                         e.name, output_z, flags, lat, e.z, e.f, e.lat);
            end else passed++;
            take();
        end
    endtask

    task automatic test_mid_reset();
        op_t e;
        int  lat;
        send('{"aborted", 32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 30});
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 total++;
        if (out_valid !== 1'b0 || output_z !== 32'h0 || flags !== 4'h0) begin
            $display("FAIL mid_reset: v=%b z=%h f=%b want 0/0/0",
                     out_valid, output_z, flags);
        end else passed++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send('{"after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 30});
        wait_valid(lat);
        e = exp_q.pop_front();
        total++;
        if (output_z !== e.z || flags !== e.f || lat != e.lat) begin
            $display("FAIL %s: z=%h f=%b lat=%0d want z=%h f=%b lat=%0d",
                     e.name, output_z, flags, lat, e.z, e.f, e.lat);
        end else passed++;
        take();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sequential_fp_divider.md
SEQUENTIAL_FP_DIVIDER -- requirements
Module: sequential_fp_divider

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port input_a  input  W  dividend, IEEE-754-style {sign, biased exp, mantissa}.
REQ-008 SHALL have port input_b  input  W  divisor, same format.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port output_z  output  W  quotient a/b.
REQ-012 SHALL have port flags  output  4  {invalid, div_by_zero, overflow, underflow}, valid with out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready register both operands and go to UNPACK; in_ready=0 in every other state (one operation in flight).
REQ-015 UNPACK (1 cycle): compute sign_z = sign_a^sign_b; classify operands; special case -> DONE, else -> DIVIDE.
REQ-016 Denormal inputs (exp=0, mantissa!=0) SHALL be treated as zero of the same sign.
REQ-017 Special results, evaluated in this priority order: either NaN, 0/0 or inf/inf -> canonical qNaN {0, all-ones exp, mantissa MSB=1, rest 0}, invalid=1; x/0 (x finite nonzero) -> inf with sign_z, div_by_zero=1; inf/x -> inf with sign_z; 0/x or x/inf -> zero with sign_z.
REQ-018 Normal path exponent SHALL be computed as ea - eb + (2^(EXP_W-1)-1), in EXP_W+2-bit signed arithmetic.
REQ-019 DIVIDE SHALL run exactly MAN_W+3 cycles, restoring radix-2, one quotient bit per cycle, on the (MAN_W+1)-bit significands with hidden 1; a nonzero final remainder SHALL set sticky.
REQ-020 NORM (1 cycle): if the quotient MSB is 0, shift left 1 and decrement the exponent.
REQ-021 ROUND (1 cycle): round-to-nearest-even using guard, round and sticky; mantissa carry-out SHALL increment the exponent.
REQ-022 Biased exponent >= 2^EXP_W-1 after rounding -> inf with sign_z, overflow=1.
REQ-023 Biased exponent <= 0 after rounding -> zero with sign_z, underflow=1 (flush, no denormal output).
REQ-024 DONE: out_valid=1; output_z and flags SHALL hold stable until out_ready=1, then go to IDLE in the same edge.
REQ-025 Latency, acceptance edge = cycle 0: normal result out_valid from cycle MAN_W+7 (30 at defaults); special result from cycle 2.
REQ-026 Throughput: next operand accepted no earlier than the cycle after the out_valid&&out_ready handshake.
REQ-027 flags SHALL be 0 except as set above; flags SHALL clear on leaving DONE.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, out_valid=0, output_z=0, flags=0, in_ready=1 after deassert, discarding any in-flight operation.
REQ-029 The first acceptance after rst_n deasserts SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-030 0x40C00000 / 0x40000000 (6.0/2.0) -> output_z=0x40400000, flags=0, out_valid at cycle 30.
REQ-031 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (RNE round-up), flags=0.
REQ-032 0xBF800000 / 0x00000000 -> 0xFF800000, div_by_zero=1, out_valid at cycle 2; 0x00000000/0x00000000 -> 0x7FC00000, invalid=1.
REQ-033 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, overflow=1; 0x00800000 / 0x40000000 -> 0x00000000, underflow=1.
REQ-034 Hold out_ready=0 for 5 cycles after out_valid -> output_z/flags stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst_n=0 at cycle 10 of a divide -> out_valid=0 and output_z=0 immediately; a new 6.0/2.0 after release returns 0x40400000 with normal latency.
